mem_stage: RTL
==============

Name: mem_stage

Overview:
- Memory-access pipeline stage. It consumes the execute stage's result (ALU result used as the effective address, store data, access size) and performs the data-memory transaction on a req/gnt/rvalid SRAM-style port.
- It formats load data with sign or zero extension, then hands one result per instruction to writeback over a valid/ready handshake.
- Sits between execute and writeback; it is the responder-side counterpart to execute's memory request outputs.

Parameters:
- DMEM_TIMEOUT, 256: cycles allowed in WAIT before the access is abandoned with an access fault (range 2..65535).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- ex_valid_i  in  1  execute result valid.
- ex_ready_o  out  1  stage can accept an execute result this cycle.
- ex_pc_i  in  32  instruction PC.
- ex_result_i  in  32  ALU result; this is the effective address for memory ops.
- ex_wdata_i  in  32  store data (rs2).
- ex_mem_re_i  in  1  load.
- ex_mem_we_i  in  1  store (re and we never both 1).
- ex_mem_size_i  in  2  0 = byte, 1 = half, 2 = word.
- ex_mem_unsigned_i  in  1  zero-extend load.
- ex_gr_we_i  in  1  register write enable.
- ex_rd_i  in  5  destination register.
- dmem_req_o  out  1  request.
- dmem_we_o  out  1  write.
- dmem_addr_o  out  32  word-aligned address.
- dmem_wstrb_o  out  4  byte strobes.
- dmem_wdata_o  out  32  lane-shifted store data.
- dmem_gnt_i  in  1  request accepted.
- dmem_rvalid_i  in  1  response (read data or write ack).
- dmem_rdata_i  in  32  read data.
- wb_valid_o  out  1  result to writeback valid.
- wb_ready_i  in  1  writeback accepts.
- wb_pc_o  out  32  PC.
- wb_gr_we_o  out  1  write enable, forced to 0 on exception.
- wb_rd_o  out  5  destination register.
- wb_wdata_o  out  32  load data or pass-through ALU result.
- wb_excp_o  out  2  0 = none, 1 = misaligned, 2 = access fault.

Behaviour:
- FSM states: IDLE, REQ, WAIT, DONE. Reset enters IDLE.
- Reset values: all outputs 0, except ex_ready_o = 1. Captured fields and the timeout counter reset to 0.
- ex_ready_o = (state==IDLE) | (state==DONE & wb_ready_i).
- An accept occurs when ex_valid_i & ex_ready_o. On accept, all ex_* fields are registered. The next state is:
  - DONE if not a memory op.
  - DONE with wb_excp_o = 1 if misaligned: half with addr[0] = 1, or word with addr[1:0] != 0. No dmem traffic is issued.
  - REQ otherwise.
- A simultaneous DONE handoff and new accept in the same cycle is legal and gives back-to-back throughput of 1 per cycle for non-memory ops.
- REQ state:
  - dmem_req_o = 1 and dmem_addr_o = {addr[31:2], 2'b00}.
  - dmem_we_o, dmem_wstrb_o and dmem_wdata_o are stable while req is held.
  - On dmem_gnt_i, go to WAIT and clear the counter.
  - req stays asserted until gnt, with no timeout in REQ.
- Store strobes and data:
  - Byte: wstrb = 1 << addr[1:0], data = {4{b}}.
  - Half: wstrb = 3 << addr[1:0], data = {2{h}}.
  - Word: wstrb = 4'hF, data unchanged.
  - For loads, wstrb = 0.
- WAIT state:
  - On dmem_rvalid_i, select the byte or half lane using addr[1:0] and sign- or zero-extend per ex_mem_unsigned_i.
  - For a load, capture the formatted value into wb_wdata_o. For a store, wb_wdata_o = ALU result. Then go to DONE.
  - If rvalid is absent, the counter increments. When the counter reaches DMEM_TIMEOUT-1 without rvalid, go to DONE with wb_excp_o = 2 and wb_gr_we_o = 0.
  - rvalid seen in REQ or IDLE is ignored.
- DONE state:
  - wb_valid_o = 1; all wb_* outputs are registered and held stable until wb_ready_i.
  - On wb_ready_i, go to IDLE, or directly to the next state if an accept happens the same cycle.
- Latency:
  - Non-memory op: accept in cycle N gives wb_valid_o in N+1.
  - Memory op with gnt in the first REQ cycle and rvalid one cycle later: wb_valid_o in N+3.
- Non-memory op: wb_wdata_o = ex_result_i.
- Reset mid-transaction: immediately returns to IDLE and drops dmem_req_o. A late rvalid after reset is ignored.

Test Plan:
- Non-memory op, pc = 0x80000000, result = 0x1234, rd = 5, wb_ready_i held 1 -> wb_valid_o one cycle later with wb_wdata_o = 0x1234; a second op accepted back-to-back, throughput 1/cycle.
- lb at addr 0x1003, unsigned = 0, rdata = 0x80FF_0000, gnt immediate, rvalid +1 -> dmem_addr_o = 0x1000, wb_wdata_o = 0xFFFFFF80, wb valid at N+3. Repeat as lbu -> 0x00000080.
- sh at addr 0x2002, wdata = 0xABCD1234 -> dmem_wstrb_o = 4'b1100, dmem_wdata_o = 0x12341234, dmem_we_o = 1; rvalid ack gives wb_excp_o = 0.
- lw at addr 0x3001 -> no dmem_req_o ever asserted, wb_excp_o = 1, wb_gr_we_o = 0, one-cycle latency.
- gnt delayed 3 cycles, then no rvalid for DMEM_TIMEOUT cycles -> dmem_req_o held high with stable address for those 3 cycles, then wb_excp_o = 2 and wb_gr_we_o = 0.
- wb_ready_i low for 4 cycles in DONE -> wb_* stable and ex_ready_o = 0. Async rst_i pulsed during WAIT -> outputs return to reset values in the same cycle; a subsequent stray rvalid produces no wb_valid_o.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between execute and writeback.
// Takes the execute result (effective address, store data, access size),
// performs the data-memory access over a req/gnt/rvalid port, formats load
// data, and hands one result per instruction to writeback over valid/ready.
//
// Ports:
//   clk_i, rst_i          clock (rising edge), asynchronous active-high reset
//   ex_*                  execute-stage result, valid/ready handshake
//   dmem_*                SRAM-style data-memory port (req/gnt, rvalid/rdata)
//   wb_*                  writeback result, valid/ready handshake
//   wb_excp_o             0 = none, 1 = misaligned, 2 = access fault (timeout)
module mem_stage #(
  parameter int unsigned DMEM_TIMEOUT = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ex_valid_i,
  output logic        ex_ready_o,
  input  logic [31:0] ex_pc_i,
  input  logic [31:0] ex_result_i,
  input  logic [31:0] ex_wdata_i,
  input  logic        ex_mem_re_i,
  input  logic        ex_mem_we_i,
  input  logic [1:0]  ex_mem_size_i,
  input  logic        ex_mem_unsigned_i,
  input  logic        ex_gr_we_i,
  input  logic [4:0]  ex_rd_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_wstrb_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        wb_valid_o,
  input  logic        wb_ready_i,
  output logic [31:0] wb_pc_o,
  output logic        wb_gr_we_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_wdata_o,
  output logic [1:0]  wb_excp_o
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  localparam logic [15:0] CntLast = 16'(DMEM_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, addr_q, addr_d, wdata_q, wdata_d, wb_wdata_q, wb_wdata_d;
  logic        re_q, re_d, we_q, we_d, uns_q, uns_d, gr_we_q, gr_we_d;
  logic [1:0]  size_q, size_d, excp_q, excp_d;
  logic [4:0]  rd_q, rd_d;
  logic [15:0] cnt_q, cnt_d;

  logic        accept, is_mem, misaligned, req;
  logic [3:0]  st_strb;
  logic [31:0] st_data, load_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign ex_ready_o = (state_q == StIdle) | ((state_q == StDone) & wb_ready_i);
  assign accept     = ex_valid_i & ex_ready_o;
  assign is_mem     = ex_mem_re_i | ex_mem_we_i;
  assign misaligned = ((ex_mem_size_i == 2'd1) & ex_result_i[0]) |
                      ((ex_mem_size_i == 2'd2) & (ex_result_i[1:0] != 2'b00));

  // Store lane steering from the captured fields; held stable throughout REQ.
  always_comb begin
    st_strb = 4'b0000;
    st_data = wdata_q;
    if (we_q) begin
      case (size_q)
        2'd0: begin
          st_strb = 4'b0001 << addr_q[1:0];
          st_data = {4{wdata_q[7:0]}};
        end
        2'd1: begin
          st_strb = 4'b0011 << addr_q[1:0];
          st_data = {2{wdata_q[15:0]}};
        end
        default: st_strb = 4'b1111;
      endcase
    end
  end

  assign req          = (state_q == StReq);
  assign dmem_req_o   = req;
  assign dmem_we_o    = req & we_q;
  assign dmem_addr_o  = req ? {addr_q[31:2], 2'b00} : 32'd0;
  assign dmem_wstrb_o = req ? st_strb : 4'b0000;
  assign dmem_wdata_o = req ? st_data : 32'd0;

  // Load lane selection and extension.
  always_comb begin
    case (addr_q[1:0])
      2'd0:    ld_byte = dmem_rdata_i[7:0];
      2'd1:    ld_byte = dmem_rdata_i[15:8];
      2'd2:    ld_byte = dmem_rdata_i[23:16];
      default: ld_byte = dmem_rdata_i[31:24];
    endcase
    ld_half = addr_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    case (size_q)
      2'd0:    load_data = uns_q ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'd1:    load_data = uns_q ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: load_data = dmem_rdata_i;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    re_d       = re_q;
    we_d       = we_q;
    size_d     = size_q;
    uns_d      = uns_q;
    gr_we_d    = gr_we_q;
    rd_d       = rd_q;
    wb_wdata_d = wb_wdata_q;
    excp_d     = excp_q;
    cnt_d      = cnt_q;

    case (state_q)
      StReq: begin
        if (dmem_gnt_i) begin
          state_d = StWait;
          cnt_d   = 16'd0;
        end
      end
      StWait: begin
        if (dmem_rvalid_i) begin
          state_d    = StDone;
          wb_wdata_d = re_q ? load_data : addr_q;
        end else if (cnt_q == CntLast) begin
          // Abandon the access; the faulting address is reported as the data.
          state_d    = StDone;
          excp_d     = 2'd2;
          gr_we_d    = 1'b0;
          wb_wdata_d = addr_q;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StDone: begin
        if (wb_ready_i) state_d = StIdle;
      end
      default: ;
    endcase

    // Accept overrides the DONE->IDLE transition for back-to-back issue.
    if (accept) begin
      pc_d       = ex_pc_i;
      addr_d     = ex_result_i;
      wdata_d    = ex_wdata_i;
      re_d       = ex_mem_re_i;
      we_d       = ex_mem_we_i;
      size_d     = ex_mem_size_i;
      uns_d      = ex_mem_unsigned_i;
      gr_we_d    = ex_gr_we_i;
      rd_d       = ex_rd_i;
      wb_wdata_d = ex_result_i;
      excp_d     = 2'd0;
      cnt_d      = 16'd0;
      if (!is_mem) begin
        state_d = StDone;
      end else if (misaligned) begin
        state_d = StDone;
        excp_d  = 2'd1;
        gr_we_d = 1'b0;
      end else begin
        state_d = StReq;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      pc_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      re_q       <= 1'b0;
      we_q       <= 1'b0;
      size_q     <= '0;
      uns_q      <= 1'b0;
      gr_we_q    <= 1'b0;
      rd_q       <= '0;
      wb_wdata_q <= '0;
      excp_q     <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      re_q       <= re_d;
      we_q       <= we_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      gr_we_q    <= gr_we_d;
      rd_q       <= rd_d;
      wb_wdata_q <= wb_wdata_d;
      excp_q     <= excp_d;
      cnt_q      <= cnt_d;
    end
  end

  assign wb_valid_o = (state_q == StDone);
  assign wb_pc_o    = pc_q;
  assign wb_gr_we_o = gr_we_q;
  assign wb_rd_o    = rd_q;
  assign wb_wdata_o = wb_wdata_q;
  assign wb_excp_o  = excp_q;

endmodule
